// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with one-shot / auto-reload modes and a CP0 irq line.
// Optional count prescaler is compiled in when TC_PRESCALE_EN is defined.
module tc_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_PRESET = AW'(1);
  localparam logic [AW-1:0] A_COUNT  = AW'(2);
  localparam logic [1:0]    MODE_AUTO = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("tc_timer: PRESCALE must be in 1..65535");
  end

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [1:0]    mode_q, mode_d;
  logic          im_q, im_d;
  logic [DW-1:0] preset_q, preset_d;
  logic [DW-1:0] count_q, count_d;
  logic          irq_flag_q, irq_flag_d;
  logic          tick;
  logic          wr_ctrl;
  logic          wr_preset;

`ifdef TC_PRESCALE_EN
  localparam int unsigned DIVW = 16;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PRESCALE - 1);
  logic [DIVW-1:0] div_q, div_d;
  assign tick = (div_q == DIV_LAST);
`else
  assign tick = 1'b1;
`endif

  assign wr_ctrl   = we && (addr == A_CTRL);
  assign wr_preset = we && (addr == A_PRESET);

  // Next-state: timer FSM first, then bus writes so a CTRL write overrides the INT-time EN clear.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
`ifdef TC_PRESCALE_EN
    div_d      = div_q;
`endif

    if (wr_ctrl) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
`ifdef TC_PRESCALE_EN
        div_d   = '0;
`endif
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else begin
`ifdef TC_PRESCALE_EN
          div_d = tick ? '0 : div_q + DIVW'(1);
`endif
          if (tick) begin
            if (count_q > DW'(1)) begin
              count_d = count_q - DW'(1);
            end else begin
              count_d    = '0;
              state_d    = ST_INT;
              irq_flag_d = 1'b1;
            end
          end
        end
      end
      ST_INT: begin
        if (mode_q == MODE_AUTO) begin
          irq_flag_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl) begin
      en_d   = wdata[0];
      mode_d = wdata[2:1];
      im_d   = wdata[3];
    end
    if (wr_preset) begin
      preset_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

`ifdef TC_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`endif

  // Read mux is combinational from addr; reserved address reads zero.
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      A_PRESET: rdata = preset_q;
      A_COUNT:  rdata = count_q;
      default:  rdata = '0;
    endcase
  end

  assign irq = irq_flag_q & im_q;

endmodule
